window_3x3_gen: RTL and testbench

//  Upstream feeder for the decision-tree denoise filter. Takes a raster-order 8-bit pixel stream.

---
 rtl/window_3x3_gen.sv | 211 +++++++++++++++++++++
 tb/tb_window_3x3_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// Raster-stream 3x3 window generator: two line buffers plus a 3x3 shift window, one window per interior pixel.
// Optional min/max compare tree enabled by defining WINDOW_MINMAX_EN; otherwise min/max are tied to 0/255.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int CNT_W      = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iv8Pixel,
  input  logic       iPixelValid,
  input  logic       iSof,
  output logic [7:0] ov8Pixel_a,
  output logic [7:0] ov8Pixel_b,
  output logic [7:0] ov8Pixel_c,
  output logic [7:0] ov8Pixel_d,
  output logic [7:0] ov8Pixel_fij,
  output logic [7:0] ov8Pixel_e,
  output logic [7:0] ov8Pixel_f,
  output logic [7:0] ov8Pixel_g,
  output logic [7:0] ov8Pixel_h,
  output logic [7:0] ov8Minij,
  output logic [7:0] ov8Maxij,
  output logic       oDataValid,
  output logic       oEn,
  output logic       oFrameDone,
  output logic       oSofErr
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ACTIVE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] w_col_cur;
  logic [CNT_W-1:0] w_row_cur;
  logic [CNT_W-1:0] w_col_next;
  logic [CNT_W-1:0] w_row_next;
  logic             w_accept;
  logic             w_restart;
  logic             w_emit;
  logic             w_sof_err_set;
  logic             r_valid;
  logic             r_en;
  logic             r_sof_err;

  logic [7:0]       r_lb0 [IMG_WIDTH];
  logic [7:0]       r_lb1 [IMG_WIDTH];
  logic [AW-1:0]    w_lb_addr;
  logic [7:0]       w_top;
  logic [7:0]       w_mid;

  logic [7:0]       r_win      [9];
  logic [7:0]       w_win_next [9];
  logic [7:0]       r_out      [9];
  logic [7:0]       w_col_in   [3];
  logic [7:0]       w_min;
  logic [7:0]       w_max;

  // Counters hold the position of the next pixel; an accepted iSof forces (0,0).
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_sof_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iPixelValid) begin
          if (iSof) w_accept = 1'b1;
          else      w_sof_err_set = 1'b1;
        end
      end
      S_FILL, S_ACTIVE: w_accept = iPixelValid;
      S_DONE:           w_state_next = S_IDLE;
      default:          w_state_next = S_IDLE;
    endcase

    w_restart = w_accept & iSof;
    w_col_cur = w_restart ? '0 : r_col;
    w_row_cur = w_restart ? '0 : r_row;

    if (w_col_cur == LAST_COL) begin
      w_col_next = '0;
      w_row_next = w_row_cur + ONE;
    end else begin
      w_col_next = w_col_cur + ONE;
      w_row_next = w_row_cur;
    end

    if (w_accept) begin
      if (w_restart)
        w_state_next = S_FILL;
      else if (r_state == S_FILL && w_row_cur == ONE && w_col_cur == LAST_COL)
        w_state_next = S_ACTIVE;
      else if (r_state == S_ACTIVE && w_row_cur == LAST_ROW && w_col_cur == LAST_COL)
        w_state_next = S_DONE;
    end

    w_emit = w_accept && (w_row_cur >= TWO) && (w_col_cur >= TWO);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
      r_en      <= 1'b0;
      r_sof_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_col <= w_col_next;
        r_row <= w_row_next;
      end
      r_valid <= w_emit;
      r_en    <= r_valid;
      if (w_sof_err_set) r_sof_err <= 1'b1;
    end
  end

  // Line buffers: read old contents and write the shifted column in the same cycle.
  assign w_lb_addr = w_col_cur[AW-1:0];
  assign w_top     = r_lb1[w_lb_addr];
  assign w_mid     = r_lb0[w_lb_addr];

  always_ff @(posedge iClk) begin
    if (w_accept) begin
      r_lb1[w_lb_addr] <= w_mid;
      r_lb0[w_lb_addr] <= iv8Pixel;
    end
  end

  assign w_col_in[0] = w_top;
  assign w_col_in[1] = w_mid;
  assign w_col_in[2] = iv8Pixel;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    assign w_win_next[3*gi]   = w_accept ? r_win[3*gi+1] : r_win[3*gi];
    assign w_win_next[3*gi+1] = w_accept ? r_win[3*gi+2] : r_win[3*gi+1];
    assign w_win_next[3*gi+2] = w_accept ? w_col_in[gi]  : r_win[3*gi+2];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= w_win_next[i];
        if (w_emit) r_out[i] <= w_win_next[i];
      end
    end
  end

`ifdef WINDOW_MINMAX_EN
  logic [7:0] r_min;
  logic [7:0] r_max;

  always_comb begin
    w_min = w_win_next[0];
    w_max = w_win_next[0];
    for (int i = 1; i < 9; i++) begin
      if (w_win_next[i] < w_min) w_min = w_win_next[i];
      if (w_win_next[i] > w_max) w_max = w_win_next[i];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_min <= '0;
      r_max <= '0;
    end else if (w_emit) begin
      r_min <= w_min;
      r_max <= w_max;
    end
  end

  assign ov8Minij = r_min;
  assign ov8Maxij = r_max;
`else
  // Fixed extremes: downstream filter then flags only 0/255 pixels as noise.
  assign w_min    = 8'd0;
  assign w_max    = 8'd255;
  assign ov8Minij = w_min;
  assign ov8Maxij = w_max;
`endif

  assign ov8Pixel_a   = r_out[0];
  assign ov8Pixel_b   = r_out[1];
  assign ov8Pixel_c   = r_out[2];
  assign ov8Pixel_d   = r_out[3];
  assign ov8Pixel_fij = r_out[4];
  assign ov8Pixel_e   = r_out[5];
  assign ov8Pixel_f   = r_out[6];
  assign ov8Pixel_g   = r_out[7];
  assign ov8Pixel_h   = r_out[8];
  assign oDataValid   = r_valid;
  assign oEn          = r_en;
  assign oFrameDone   = (r_state == S_DONE);
  assign oSofErr      = r_sof_err;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen (8x4 image) against an image-array reference model.
module tb_window_3x3_gen;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       iRst = 1'b1;
  logic [7:0] iv8Pixel = '0;
  logic       iPixelValid = 1'b0;
  logic       iSof = 1'b0;
  logic [7:0] ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij;
  logic [7:0] ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h;
  logic [7:0] ov8Minij, ov8Maxij;
  logic       oDataValid, oEn, oFrameDone, oSofErr;

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(16)) dut (
    .iClk(clk), .iRst(iRst), .iv8Pixel(iv8Pixel), .iPixelValid(iPixelValid), .iSof(iSof),
    .ov8Pixel_a(ov8Pixel_a), .ov8Pixel_b(ov8Pixel_b), .ov8Pixel_c(ov8Pixel_c),
    .ov8Pixel_d(ov8Pixel_d), .ov8Pixel_fij(ov8Pixel_fij), .ov8Pixel_e(ov8Pixel_e),
    .ov8Pixel_f(ov8Pixel_f), .ov8Pixel_g(ov8Pixel_g), .ov8Pixel_h(ov8Pixel_h),
    .ov8Minij(ov8Minij), .ov8Maxij(ov8Maxij), .oDataValid(oDataValid), .oEn(oEn),
    .oFrameDone(oFrameDone), .oSofErr(oSofErr)
  );

  // Reference model: frame image, next raster position, frame phase (0 idle, 1 in frame, 2 done).
  int         img [H][W];
  int         phase = 0;
  int         nr = 0;
  int         nc = 0;
  logic [7:0] exp_out [9];
  logic [7:0] exp_min = 8'd0;
  logic [7:0] exp_max = 8'd0;
  bit         exp_valid = 0;
  bit         exp_en = 0;
  bit         exp_done = 0;
  bit         exp_err = 0;
  int         checks = 0;
  int         errors = 0;
  int         win_seen = 0;
  int         cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] p);
    bit acc, emit, last;
    int r, c;
    iRst = rst; iPixelValid = v; iSof = s; iv8Pixel = p;
    @(posedge clk);
    #1;
    cyc++;
    emit = 0;
    if (rst) begin
      phase = 0; exp_valid = 0; exp_en = 0; exp_done = 0; exp_err = 0;
      exp_min = 0; exp_max = 0;
      for (int i = 0; i < 9; i++) exp_out[i] = 8'd0;
    end else begin
      acc = v && ((phase == 0 && s) || phase == 1);
      if (v && phase == 0 && !s) exp_err = 1;
      if (acc) begin
        r = s ? 0 : nr;
        c = s ? 0 : nc;
        img[r][c] = int'(p);
        emit = (r >= 2) && (c >= 2);
        last = (r == H - 1) && (c == W - 1);
        if (c == W - 1) begin nc = 0; nr = r + 1; end
        else begin nc = c + 1; nr = r; end
        phase = last ? 2 : 1;
        if (emit) begin
          exp_min = 8'd255;
          exp_max = 8'd0;
          for (int i = 0; i < 9; i++) begin
            exp_out[i] = 8'(img[r - 2 + i / 3][c - 2 + i % 3]);
            if (exp_out[i] < exp_min) exp_min = exp_out[i];
            if (exp_out[i] > exp_max) exp_max = exp_out[i];
          end
        end
      end else if (phase == 2) begin
        phase = 0;
      end
      exp_en    = exp_valid;
      exp_valid = emit;
      exp_done  = (phase == 2);
    end
    if (oDataValid === 1'b1) win_seen++;
    chk("valid", 32'(oDataValid), 32'(exp_valid));
    chk("en", 32'(oEn), 32'(exp_en));
    chk("frame_done", 32'(oFrameDone), 32'(exp_done));
    chk("sof_err", 32'(oSofErr), 32'(exp_err));
    chk("tap_a", 32'(ov8Pixel_a), 32'(exp_out[0]));
    chk("tap_b", 32'(ov8Pixel_b), 32'(exp_out[1]));
    chk("tap_c", 32'(ov8Pixel_c), 32'(exp_out[2]));
    chk("tap_d", 32'(ov8Pixel_d), 32'(exp_out[3]));
    chk("tap_fij", 32'(ov8Pixel_fij), 32'(exp_out[4]));
    chk("tap_e", 32'(ov8Pixel_e), 32'(exp_out[5]));
    chk("tap_f", 32'(ov8Pixel_f), 32'(exp_out[6]));
    chk("tap_g", 32'(ov8Pixel_g), 32'(exp_out[7]));
    chk("tap_h", 32'(ov8Pixel_h), 32'(exp_out[8]));
`ifdef WINDOW_MINMAX_EN
    chk("min", 32'(ov8Minij), 32'(exp_min));
    chk("max", 32'(ov8Maxij), 32'(exp_max));
`else
    chk("min_tied", 32'(ov8Minij), 32'd0);
    chk("max_tied", 32'(ov8Maxij), 32'd255);
`endif
  endtask

  // gap: 0 continuous, 1 alternate valid/idle, 2 random idle cycles
  task automatic send_frame(input bit ramp, input int gap, input int k_start, input int k_stop);
    logic [7:0] pix;
    for (int k = k_start; k < k_stop; k++) begin
      pix = ramp ? 8'(8 * (k / W) + (k % W)) : 8'($urandom);
      step(0, 1, (k == 0), pix);
      if (gap == 1) step(0, 0, 0, 8'($urandom));
      if (gap == 2 && $urandom_range(0, 2) == 0) step(0, 0, 0, 8'($urandom));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 1) == 1, 8'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 9; i++) exp_out[i] = 8'd0;
    step(1, 0, 0, 8'd0);
    step(1, 1, 1, 8'd77);

    // Ramp frame, continuous valid
    win_seen = 0;
    send_frame(1, 0, 0, W * H);
    idle(3);
    chk("t1_window_count", 32'(win_seen), 32'd12);

    // Same frame with valid toggled every cycle
    win_seen = 0;
    send_frame(1, 1, 0, W * H);
    idle(3);
    chk("t2_window_count", 32'(win_seen), 32'd12);

    // Pixels without iSof after reset are dropped and set the sticky error
    step(1, 0, 0, 8'd0);
    win_seen = 0;
    for (int i = 0; i < 6; i++) step(0, 1, 0, 8'($urandom));
    idle(2);
    chk("t3_no_windows", 32'(win_seen), 32'd0);
    send_frame(0, 2, 0, W * H);
    idle(3);
    chk("t3_window_count", 32'(win_seen), 32'd12);

    // iSof at row 2, col 3 restarts the frame
    win_seen = 0;
    send_frame(1, 0, 0, 2 * W + 3);
    send_frame(0, 0, 0, W * H);
    idle(3);
    chk("t4_window_count", 32'(win_seen), 32'd13);

    // Reset mid-ACTIVE, then a clean random frame
    send_frame(0, 2, 0, 2 * W + 6);
    step(1, 0, 0, 8'd0);
    win_seen = 0;
    send_frame(0, 2, 0, W * H);
    step(0, 1, 1, 8'd200);
    idle(3);
    chk("t5_window_count", 32'(win_seen), 32'd12);

    // Random frames with random gaps
    for (int f = 0; f < 3; f++) begin
      win_seen = 0;
      send_frame(0, 2, 0, W * H);
      idle(2);
      chk("t6_window_count", 32'(win_seen), 32'd12);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
